// File: rtl/noc_output_port_scheduler_pkg.sv
// Shared types and constants for the NoC output-port VC scheduler.
package noc_output_port_scheduler_pkg;

  localparam int unsigned Noc_VC_Channel = 4;

  typedef enum logic {
    SCHED_IDLE   = 1'b0,
    SCHED_LOCKED = 1'b1
  } e_sched_state;

  // Pointer width that stays legal for a single-channel port.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_output_port_scheduler_rr_arbiter.sv
// Combinational rotating-priority picker: first requester at/after ptr, wrapping.
module noc_rr_arbiter
  import noc_output_port_scheduler_pkg::*;
#(
  parameter  int unsigned CHANNELS = Noc_VC_Channel,
  localparam int unsigned PTR_W    = ptr_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [CHANNELS-1:0] gnt,
  output logic                any
);

  logic [PTR_W-1:0] idx;

  // Walk the channels starting at ptr and grant the first requester found.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = PTR_W'((32'(ptr) + k) % CHANNELS);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_port_scheduler.sv
// Per-output-port wormhole VC scheduler with round-robin arbitration and lock watchdog.
module noc_output_port_scheduler
  import noc_output_port_scheduler_pkg::*;
#(
  parameter int unsigned CHANNELS     = Noc_VC_Channel,
  parameter int unsigned LOCK_TIMEOUT = 256
) (
  input  logic                noc_clk,
  input  logic                noc_rst_n,
  input  logic [CHANNELS-1:0] request,
  input  logic [CHANNELS-1:0] free,
  input  logic [CHANNELS-1:0] start_of_packet,
  input  logic [CHANNELS-1:0] end_of_packet,
  input  logic [CHANNELS-1:0] out_vc_ready,
  output logic [CHANNELS-1:0] grant,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned PTR_W = ptr_width(CHANNELS);

  e_sched_state        state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0]     wd_cnt_q, wd_cnt_d;

  logic [CHANNELS-1:0] eligible_c;
  logic [CHANNELS-1:0] arb_req_c;
  logic [CHANNELS-1:0] arb_gnt_c;
  logic                arb_any_c;
  logic [PTR_W-1:0]    arb_ptr_c;
  logic [PTR_W-1:0]    owner_c;
  logic [PTR_W-1:0]    owner_next_c;
  logic                owner_eop_c;
  logic                owner_xfer_c;

  // Owner index decode and the arbiter inputs; the current owner is masked on release.
  always_comb begin
    owner_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant_q[i]) owner_c = PTR_W'(i);
    end
    owner_next_c = (32'(owner_c) == CHANNELS - 1) ? '0 : owner_c + PTR_W'(1);
    owner_eop_c  = |(end_of_packet & grant_q);
    owner_xfer_c = |(request & free & grant_q);
    eligible_c   = start_of_packet & request & out_vc_ready;
    arb_req_c    = eligible_c & ~grant_q;
    arb_ptr_c    = (state_q == SCHED_LOCKED) ? owner_next_c : rr_ptr_q;
  end

  noc_rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req (arb_req_c),
    .ptr (arb_ptr_c),
    .gnt (arb_gnt_c),
    .any (arb_any_c)
  );

  // Next-state: header arbitration, wormhole hold, tail hand-off and watchdog.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    busy_d        = busy_q;
    rr_ptr_d      = rr_ptr_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      SCHED_IDLE: begin
        wd_cnt_d = '0;
        if (arb_any_c) begin
          grant_d = arb_gnt_c;
          busy_d  = 1'b1;
          state_d = SCHED_LOCKED;
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      SCHED_LOCKED: begin
        if (owner_eop_c) begin
          rr_ptr_d = owner_next_c;
          wd_cnt_d = '0;
          if (arb_any_c) begin
            grant_d = arb_gnt_c;
          end else begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = SCHED_IDLE;
          end
        end else if (owner_xfer_c) begin
          wd_cnt_d = '0;
        end else if (wd_cnt_q != TO_W'(LOCK_TIMEOUT)) begin
          wd_cnt_d = wd_cnt_q + TO_W'(1);
          if (wd_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) timeout_err_d = 1'b1;
        end
      end
      default: begin
        state_d = SCHED_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any held lock.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q       <= SCHED_IDLE;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= '0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      rr_ptr_q      <= rr_ptr_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_noc_output_port_scheduler.sv
// Scoreboard bench for noc_output_port_scheduler (CHANNELS=4, LOCK_TIMEOUT=8).
module tb_noc_output_port_scheduler;

  localparam int unsigned CH = 4;

  logic          noc_clk = 1'b0;
  logic          noc_rst_n;
  logic [CH-1:0] request;
  logic [CH-1:0] free;
  logic [CH-1:0] start_of_packet;
  logic [CH-1:0] end_of_packet;
  logic [CH-1:0] out_vc_ready;
  logic [CH-1:0] grant;
  logic          busy;
  logic          timeout_err;

  always #5 noc_clk = ~noc_clk;

  noc_output_port_scheduler #(
    .CHANNELS     (CH),
    .LOCK_TIMEOUT (8)
  ) dut (
    .noc_clk         (noc_clk),
    .noc_rst_n       (noc_rst_n),
    .request         (request),
    .free            (free),
    .start_of_packet (start_of_packet),
    .end_of_packet   (end_of_packet),
    .out_vc_ready    (out_vc_ready),
    .grant           (grant),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  // Packet source state per VC: flits in current packet (0 = none), position, extra packets.
  int unsigned   pkt_len     [CH];
  int unsigned   flit_idx    [CH];
  int unsigned   repeat_pkts [CH];
  logic [CH-1:0] free_en;
  logic [CH-1:0] exp_q[$];
  logic          new_grant;
  int            compared   = 0;
  int            mismatched = 0;

  function automatic bit sources_empty();
    bit e = 1'b1;
    for (int i = 0; i < CH; i++) if (pkt_len[i] != 0) e = 1'b0;
    return e;
  endfunction

  task automatic clear_sources();
    for (int i = 0; i < CH; i++) begin
      pkt_len[i]     = 0;
      flit_idx[i]    = 0;
      repeat_pkts[i] = 0;
    end
    free_en         = '1;
    out_vc_ready    = '1;
    request         = '0;
    free            = '0;
    start_of_packet = '0;
    end_of_packet   = '0;
    exp_q.delete();
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < CH; i++) begin
      if (pkt_len[i] != 0) begin
        request[i]         = 1'b1;
        start_of_packet[i] = (flit_idx[i] == 0);
        free[i]            = free_en[i];
        end_of_packet[i]   = grant[i] & free_en[i] & (flit_idx[i] == pkt_len[i] - 1);
      end else begin
        request[i]         = 1'b0;
        start_of_packet[i] = 1'b0;
        free[i]            = 1'b0;
        end_of_packet[i]   = 1'b0;
      end
    end
  endtask

  // One clock: drive, advance the sources on the edge, then pop the scoreboard on a new grant.
  task automatic cycle();
    logic [CH-1:0] g_prev;
    logic [CH-1:0] e_prev;
    logic [CH-1:0] exp_g;
    drive_inputs();
    g_prev = grant;
    e_prev = end_of_packet;
    @(posedge noc_clk);
    for (int i = 0; i < CH; i++) begin
      if (g_prev[i] && free[i] && pkt_len[i] != 0) begin
        flit_idx[i]++;
        if (flit_idx[i] == pkt_len[i]) begin
          flit_idx[i] = 0;
          if (repeat_pkts[i] > 0) repeat_pkts[i]--;
          else pkt_len[i] = 0;
        end
      end
    end
    #1;
    new_grant = (grant != '0) && ((g_prev == '0) || ((e_prev & g_prev) != '0));
    if (new_grant) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL sb_grant: got grant=%b, required no new grant", grant);
      end else begin
        exp_g = exp_q.pop_front();
        if (grant !== exp_g || busy !== 1'b1) begin
          mismatched++;
          $display("FAIL sb_grant: got grant=%b busy=%b, required grant=%b busy=1",
                   grant, busy, exp_g);
        end
      end
    end
  endtask

  task automatic apply_reset();
    noc_rst_n = 1'b0;
    clear_sources();
    @(posedge noc_clk);
    #1;
    noc_rst_n = 1'b1;
  endtask

  task automatic run_until_idle(input string name, output int ncyc);
    bit done = 1'b0;
    ncyc = 0;
    while (!done && ncyc < 100) begin
      if (sources_empty() && grant == '0) done = 1'b1;
      else begin
        cycle();
        ncyc++;
      end
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL %s_drain: got still busy after %0d cycles, required idle", name, ncyc);
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_sb_left: got %0d grants never seen, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    int n;
    noc_rst_n = 1'b0;
    clear_sources();
    repeat (2) @(posedge noc_clk);
    #1;
    compared++;
    if (grant !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_vals: got grant=%b busy=%b to=%b, required 0000/0/0",
               grant, busy, timeout_err);
    end
    noc_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      compared++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL idle_c%0d: got grant=%b busy=%b, required 0000/0", c, grant, busy);
      end
    end
    pkt_len[2] = 2;
    exp_q.push_back(4'b0100);
    cycle();
    compared++;
    if (grant !== 4'b0100 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL first_grant_latency: got grant=%b busy=%b, required 0100/1", grant, busy);
    end
    run_until_idle("first", n);
  endtask

  task automatic test_round_robin();
    int gap = 0;
    int grants = 0;
    bit started = 1'b0;
    apply_reset();
    for (int i = 0; i < CH; i++) begin
      pkt_len[i]     = 3;
      repeat_pkts[i] = 10;
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int c = 0; c < 40 && grants < 5; c++) begin
      cycle();
      gap++;
      if (started) begin
        compared++;
        if (grant === 4'b0000) begin
          mismatched++;
          $display("FAIL rr_bubble: got grant=%b at cycle %0d, required nonzero", grant, c);
        end
      end
      if (new_grant) begin
        if (started) begin
          compared++;
          if (gap != 3) begin
            mismatched++;
            $display("FAIL rr_pkt_len: got %0d cycles per grant, required 3", gap);
          end
        end
        started = 1'b1;
        gap     = 0;
        grants++;
      end
    end
    compared++;
    if (grants != 5 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL rr_order: got %0d grants, %0d unseen, required 5 and 0", grants, exp_q.size());
    end
  endtask

  task automatic test_hold_lock();
    int n;
    bit held_ok = 1'b1;
    apply_reset();
    pkt_len[1] = 4;
    exp_q.push_back(4'b0010);
    cycle();
    cycle();
    pkt_len[3] = 1;
    exp_q.push_back(4'b1000);
    for (int c = 0; c < 10 && pkt_len[1] != 0; c++) begin
      cycle();
      if (pkt_len[1] != 0 && grant !== 4'b0010) held_ok = 1'b0;
    end
    compared++;
    if (!held_ok) begin
      mismatched++;
      $display("FAIL hold_lock: got grant change before VC1 tail, required 0010 held");
    end
    compared++;
    if (grant !== 4'b1000) begin
      mismatched++;
      $display("FAIL hold_handoff: got grant=%b after VC1 tail, required 1000", grant);
    end
    run_until_idle("hold", n);
  endtask

  task automatic test_out_vc_ready();
    int n;
    apply_reset();
    out_vc_ready = 4'b1110;
    pkt_len[0]   = 2;
    pkt_len[1]   = 2;
    exp_q.push_back(4'b0010);
    cycle();
    compared++;
    if (grant !== 4'b0010) begin
      mismatched++;
      $display("FAIL ovr_block: got grant=%b, required 0010", grant);
    end
    out_vc_ready = 4'b1111;
    exp_q.push_back(4'b0001);
    run_until_idle("ovr", n);
  endtask

  task automatic test_single_flit();
    int n;
    apply_reset();
    pkt_len[0]     = 1;
    repeat_pkts[0] = 3;
    pkt_len[2]     = 1;
    repeat_pkts[2] = 3;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0100);
    end
    run_until_idle("single", n);
    compared++;
    if (n != 9) begin
      mismatched++;
      $display("FAIL single_no_bubble: got %0d cycles for 8 packets, required 9", n);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    pkt_len[3] = 2;
    free_en    = 4'b0111;
    exp_q.push_back(4'b1000);
    cycle();
    for (int k = 1; k <= 8; k++) begin
      cycle();
      compared++;
      if (timeout_err !== (k >= 8) || grant !== 4'b1000) begin
        mismatched++;
        $display("FAIL timeout_k%0d: got to=%b grant=%b, required to=%b grant=1000",
                 k, timeout_err, grant, (k >= 8));
      end
    end
    #2;
    noc_rst_n = 1'b0;
    #1;
    compared++;
    if (grant !== 4'b0000 || timeout_err !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_midlock: got grant=%b to=%b busy=%b, required 0000/0/0",
               grant, timeout_err, busy);
    end
    clear_sources();
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    cycle();
    compared++;
    if (grant !== 4'b0000 || timeout_err !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset_idle: got grant=%b to=%b, required 0000/0", grant, timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold_lock();
    test_out_vc_ready();
    test_single_flit();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
